// File: rtl/dmem_sized_if.sv
// Request/response bundle for the sized data memory.
// The master drives requests and the slave returns one registered response per request.
interface dmem_sized_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid,
        output req_we,
        output req_size,
        output req_unsigned,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_size,
        input  req_unsigned,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );
endinterface

// File: rtl/dmem_sized.sv
// Word-organised data memory with byte/half/word little-endian access and a fixed
// response latency; misaligned or reserved-size requests return an error response.
module dmem_sized #(
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned LATENCY = 1
) (
    input logic         clk,
    input logic         rst_n,
    dmem_sized_if.slave bus_io
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic        hold_err_q, hold_err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [Depth];

    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic              accept;
    logic              req_err;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;
    logic [31:0]       result_data;
    logic              unused_addr;

    // Upper address bits are dropped so accesses wrap modulo the depth.
    assign idx         = bus_io.req_addr[ADDR_W+1:2];
    assign lane        = bus_io.req_addr[1:0];
    assign unused_addr = ^bus_io.req_addr[31:ADDR_W+2];

    // Gated with rst_n so the block never advertises readiness while held in reset.
    assign bus_io.req_ready = rst_n & (state_q == StIdle);
    assign accept           = bus_io.req_valid & bus_io.req_ready;

    always_comb begin : decode
        req_err   = 1'b0;
        be        = 4'b0000;
        wdata_rep = 32'h0;
        case (bus_io.req_size)
            SizeByte: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{bus_io.req_wdata[7:0]}};
            end
            SizeHalf: begin
                req_err   = lane[0];
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus_io.req_wdata[15:0]}};
            end
            SizeWord: begin
                req_err   = |lane;
                be        = 4'b1111;
                wdata_rep = bus_io.req_wdata;
            end
            default: req_err = 1'b1;
        endcase
    end

    assign rd_word = mem_q[idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin : extract
        load_val = 32'h0;
        case (bus_io.req_size)
            SizeByte: load_val = bus_io.req_unsigned ? {24'h0, rd_byte}
                                                     : {{24{rd_byte[7]}}, rd_byte};
            SizeHalf: load_val = bus_io.req_unsigned ? {16'h0, rd_half}
                                                     : {{16{rd_half[15]}}, rd_half};
            SizeWord: load_val = rd_word;
            default:  load_val = 32'h0;
        endcase
    end

    // Stores and errored requests answer with zero data.
    assign result_data = (req_err || bus_io.req_we) ? 32'h0 : load_val;

    // Memory is deliberately outside the reset domain: contents survive rst_n.
    always_ff @(posedge clk) begin : mem_write
        if (accept && bus_io.req_we && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    always_comb begin : fsm_next
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_data_d = hold_data_q;
        hold_err_d  = hold_err_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    hold_data_d = result_data;
                    hold_err_d  = req_err;
                    if (LATENCY == 1) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 3'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 3'd0;
            end
        endcase

        // Response data is only non-zero for the single RESP cycle.
        rdata_d = (state_d == StResp) ? hold_data_d : 32'h0;
        err_d   = (state_d == StResp) ? hold_err_d : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin : fsm_regs
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= 3'd0;
            hold_data_q <= 32'h0;
            hold_err_q  <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_data_q <= hold_data_d;
            hold_err_q  <= hold_err_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus_io.rsp_valid = (state_q == StResp);
    assign bus_io.rsp_rdata = rdata_q;
    assign bus_io.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_sized.sv
// Directed bench for dmem_sized at LATENCY=2, ADDR_W=11: data, error, wrap,
// reset-abort and back-to-back acceptance behaviour.
module tb_dmem_sized;
    localparam int unsigned Lat = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dmem_sized_if bus ();

    dmem_sized #(
        .ADDR_W (11),
        .LATENCY(Lat)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus_io(bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request, checks latency/busy timing and the response, then the idle cycle.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int          guard;
        int          lat;
        int          busy;
        logic [31:0] got_rdata;
        logic        got_err;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat       = 0;
        busy      = 0;
        got_rdata = 32'h0;
        got_err   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!bus.req_ready) busy++;
            if (bus.rsp_valid) begin
                lat       = k;
                got_rdata = bus.rsp_rdata;
                got_err   = bus.rsp_err;
                break;
            end
            @(posedge clk);
            #1;
        end
        check_eq({tag, ".lat"}, lat, Lat);
        check_eq({tag, ".busy"}, busy, Lat);
        check_eq({tag, ".rdata"}, got_rdata, exp_rdata);
        check_eq({tag, ".err"}, {31'h0, got_err}, {31'h0, exp_err});
        @(posedge clk);
        #1;
        check_eq({tag, ".rdy_after"}, {31'h0, bus.req_ready}, 32'h1);
        check_eq({tag, ".vld_after"}, {31'h0, bus.rsp_valid}, 32'h0);
        check_eq({tag, ".rdata_after"}, bus.rsp_rdata, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] mask;
        int         pulses;

        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        rst_n            = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.ready", {31'h0, bus.req_ready}, 32'h0);
        check_eq("rst.valid", {31'h0, bus.rsp_valid}, 32'h0);
        check_eq("rst.rdata", bus.rsp_rdata, 32'h0);
        check_eq("rst.err", {31'h0, bus.rsp_err}, 32'h0);
        rst_n = 1'b1;
        #1;
        check_eq("rst.ready_release", {31'h0, bus.req_ready}, 32'h1);

        // Word store/load.
        do_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte store, then sized loads with sign/zero extension.
        do_req("sb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5, 32'h0, 1'b0);
        do_req("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADA5EF, 1'b0);
        do_req("lb11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFFFFA5, 1'b0);
        do_req("lbu11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h000000A5, 1'b0);
        do_req("lh12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);

        // Error cases: no write, zero data.
        do_req("lh13", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
        do_req("sw12", 1'b1, 2'b10, 1'b0, 32'h12, 32'hCAFEF00D, 32'h0, 1'b1);
        do_req("lw10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADA5EF, 1'b0);
        do_req("sz11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);

        // Address wrap modulo depth.
        do_req("sw2000", 1'b1, 2'b10, 1'b0, 32'h2000, 32'h12345678, 32'h0, 1'b0);
        do_req("lw0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0);

        // Reset during WAIT of a load aborts it.
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h10;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check_eq("abort.wait_ready", {31'h0, bus.req_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        check_eq("abort.valid", {31'h0, bus.rsp_valid}, 32'h0);
        check_eq("abort.rdata", bus.rsp_rdata, 32'h0);
        check_eq("abort.err", {31'h0, bus.rsp_err}, 32'h0);
        check_eq("abort.ready_in_rst", {31'h0, bus.req_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("abort.ready_release", {31'h0, bus.req_ready}, 32'h1);
        pulses = 0;
        repeat (4) begin
            if (bus.rsp_valid) pulses++;
            @(posedge clk);
            #1;
        end
        check_eq("abort.no_pulse", pulses, 0);
        do_req("abort.lw0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0);
        do_req("abort.lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADA5EF, 1'b0);

        // req_valid held for 6 cycles: accepts only at cycles 0 and 3.
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b10;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h10;
        bus.req_valid    = 1'b1;
        mask   = 6'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.req_ready) mask[i] = 1'b1;
            @(posedge clk);
            #1;
            if (bus.rsp_valid) pulses++;
        end
        bus.req_valid = 1'b0;
        check_eq("held.accept_mask", {26'h0, mask}, 32'h09);
        check_eq("held.rsp_pulses", pulses, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
